coin_acceptor: RTL and testbench

Upstream front end for `vending_machine_18105070`. It takes the two raw coin-sensor lines from the acceptor mechanism and synchronises and debounces them. It classifies each inserted coin and queues it in a small FIFO, then presents coins to the vending machine as one-cycle codes on its 2-bit `in` port: 0 = none, 1 = 5-unit coin, 2 = 10-unit coin. Coins that cannot be accepted are flagged on `reject` so the mechanism routes them to the return chute.

---
 rtl/coin_acceptor.sv | 156 +++++++++++++++
 tb/tb_coin_acceptor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces two coin sensors, classifies
// each insertion, queues accepted coins and emits them as one-cycle codes.
module coin_acceptor #(
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sense_5,
  input  logic                          sense_10,
  input  logic                          enable,
  output logic [1:0]                    coin,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          full,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAPW = 2'd2
  } state_t;

  // Bit 0 carries the 5-unit sensor, bit 1 the 10-unit sensor.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] stable;
  logic [1:0] rise;

  assign raw = {sense_10, sense_5};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic          lvl;
    logic [CW-1:0] cnt;
    logic          settle;

    // settle: this edge completes DEBOUNCE consecutive differing cycles.
    assign settle    = (sync2[g] != lvl) && (cnt == CW'(DEBOUNCE - 1));
    assign rise[g]   = settle && sync2[g];
    assign stable[g] = lvl;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync2[g] == lvl) begin
        cnt <= '0;
      end else if (settle) begin
        lvl <= sync2[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic       event_any;
  logic       jam;
  logic       fifo_full;
  logic       push;
  logic       pop;
  logic       reject_next;
  logic [1:0] push_code;

  // Jam: both rise together, or one rises while the other is already held.
  assign event_any   = |rise;
  assign jam         = (&rise) | (rise[0] & stable[1]) | (rise[1] & stable[0]);
  assign fifo_full   = (pending == PW'(FIFO_DEPTH));
  assign push        = event_any & ~jam & enable & ~fifo_full;
  assign reject_next = event_any & ~push;
  assign push_code   = rise[0] ? 2'd1 : 2'd2;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] pending_next;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_comb begin
    pending_next = pending;
    if (push && !pop) pending_next = pending + 1'b1;
    else if (!push && pop) pending_next = pending - 1'b1;
  end

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    hold;

  assign fsm_state = state;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          pop        = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT:    state_next = (GAP > 0) ? GAPW : IDLE;
      GAPW:    if (gap_cnt == GW'(GAP - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // coin is a one-cycle strobe: nonzero for exactly the cycle after EMIT, no backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      hold    <= 2'd0;
      coin    <= 2'd0;
      reject  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
      full    <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= (state == GAPW) ? gap_cnt + 1'b1 : '0;
      if (pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      coin    <= (state == EMIT) ? hold : 2'd0;
      reject  <= reject_next;
      pending <= pending_next;
      full    <= (pending_next == PW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: instance a (DEBOUNCE=4, GAP=1) for clean/bounce/jam/enable,
// instance b (DEBOUNCE=1, GAP=8) for overflow and mid-operation reset.
module tb_coin_acceptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, sense_5_a, sense_10_a, enable_a;
  logic [1:0] coin_a, fsm_state_a;
  logic       reject_a, full_a;
  logic [2:0] pending_a;

  logic       rst_b, sense_5_b, sense_10_b, enable_b;
  logic [1:0] coin_b, fsm_state_b;
  logic       reject_b, full_b;
  logic [2:0] pending_b;

  coin_acceptor #(.DEBOUNCE(4), .FIFO_DEPTH(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst_a), .sense_5(sense_5_a), .sense_10(sense_10_a),
    .enable(enable_a), .coin(coin_a), .reject(reject_a), .pending(pending_a),
    .full(full_a), .fsm_state(fsm_state_a)
  );

  coin_acceptor #(.DEBOUNCE(1), .FIFO_DEPTH(4), .GAP(8)) u_b (
    .clk(clk), .rst(rst_b), .sense_5(sense_5_b), .sense_10(sense_10_b),
    .enable(enable_b), .coin(coin_b), .reject(reject_b), .pending(pending_b),
    .full(full_b), .fsm_state(fsm_state_b)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q_a[$];
  logic [1:0] exp_q_b[$];
  int rej_seen_a  = 0;
  int rej_seen_b  = 0;
  int last_coin_a = -1;
  int last_rej_a  = -1;
  int last_rej_b  = -1;
  int prev_coin_b = -1;
  logic prev_cv_a  = 1'b0;
  logic prev_rej_a = 1'b0;
  logic prev_rej_b = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: pop one expected code whenever a coin strobe appears.
  always @(posedge clk) begin
    #1;
    if (coin_a != 2'd0) begin
      last_coin_a = cyc;
      if (exp_q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_coin_unexpected: got %0d want none (cycle %0d)", coin_a, cyc);
      end else begin
        check("a_coin", int'(coin_a), int'(exp_q_a.pop_front()));
      end
      check("a_coin_one_cycle", int'(prev_cv_a), 0);
    end
    prev_cv_a = (coin_a != 2'd0);
    if (reject_a) begin
      rej_seen_a++;
      last_rej_a = cyc;
      check("a_reject_one_cycle", int'(prev_rej_a), 0);
    end
    prev_rej_a = reject_a;
  end

  always @(posedge clk) begin
    #1;
    if (coin_b != 2'd0) begin
      if (exp_q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_coin_unexpected: got %0d want none (cycle %0d)", coin_b, cyc);
      end else begin
        check("b_coin", int'(coin_b), int'(exp_q_b.pop_front()));
      end
      if (prev_coin_b >= 0) check("b_coin_period", cyc - prev_coin_b, 10);
      prev_coin_b = cyc;
    end
    if (reject_b) begin
      rej_seen_b++;
      last_rej_b = cyc;
      check("b_reject_one_cycle", int'(prev_rej_b), 0);
    end
    prev_rej_b = reject_b;
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return #1 after the rising edge numbered t.
  task automatic at_edge(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_a(input logic s5, input logic s10, input int hold, input int rest);
    sense_5_a  = s5;
    sense_10_a = s10;
    negs(hold);
    sense_5_a  = 1'b0;
    sense_10_a = 1'b0;
    negs(rest);
  endtask

  task automatic ins_b(input logic is5);
    sense_5_b  = is5;
    sense_10_b = ~is5;
    negs(2);
    sense_5_b  = 1'b0;
    sense_10_b = 1'b0;
    negs(2);
  endtask

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int k;
    rst_a = 1'b0; sense_5_a = 1'b0; sense_10_a = 1'b0; enable_a = 1'b1;
    rst_b = 1'b0; sense_5_b = 1'b0; sense_10_b = 1'b0; enable_b = 1'b1;
    negs(3);
    check("rst_coin", int'(coin_a), 0);
    check("rst_reject", int'(reject_a), 0);
    check("rst_pending", int'(pending_a), 0);
    check("rst_full", int'(full_a), 0);
    check("rst_state", int'(fsm_state_a), 0);
    check("rst_b_pending", int'(pending_b), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    negs(5);

    // Clean 5 then clean 10: coin at k+DEBOUNCE+3.
    k = cyc + 1;
    exp_q_a.push_back(2'd1);
    pulse_a(1'b1, 1'b0, 10, 12);
    check("a_clean5_latency", last_coin_a, k + 7);
    k = cyc + 1;
    exp_q_a.push_back(2'd2);
    pulse_a(1'b0, 1'b1, 10, 12);
    check("a_clean10_latency", last_coin_a, k + 7);
    check("a_clean_rejects", rej_seen_a, 0);

    // Bounce: 2-cycle toggles, then a solid hold gives exactly one coin.
    for (int i = 0; i < 3; i++) begin
      sense_5_a = 1'b1;
      negs(2);
      sense_5_a = 1'b0;
      negs(2);
    end
    k = cyc + 1;
    exp_q_a.push_back(2'd1);
    pulse_a(1'b1, 1'b0, 10, 12);
    check("a_bounce_latency", last_coin_a, k + 7);
    pulse_a(1'b0, 1'b1, 3, 12);
    pulse_a(1'b1, 1'b0, 1, 12);
    check("a_glitch_rejects", rej_seen_a, 0);
    check("a_glitch_queue", exp_q_a.size(), 0);

    // Jam: simultaneous rise, then 10 rising while 5 is held.
    k = cyc + 1;
    sense_5_a = 1'b1;
    sense_10_a = 1'b1;
    negs(10);
    check("a_jam_both_reject_time", last_rej_a, k + 5);
    sense_10_a = 1'b0;
    negs(10);
    k = cyc + 1;
    sense_10_a = 1'b1;
    negs(10);
    check("a_jam_held_reject_time", last_rej_a, k + 5);
    sense_5_a = 1'b0;
    sense_10_a = 1'b0;
    negs(12);
    check("a_jam_rejects", rej_seen_a, 2);
    check("a_jam_pending", int'(pending_a), 0);

    // Disabled insertion is rejected; re-enabled insertion is accepted.
    enable_a = 1'b0;
    k = cyc + 1;
    pulse_a(1'b0, 1'b1, 10, 12);
    check("a_disabled_reject_time", last_rej_a, k + 5);
    enable_a = 1'b1;
    k = cyc + 1;
    exp_q_a.push_back(2'd1);
    pulse_a(1'b1, 1'b0, 10, 12);
    check("a_reenabled_latency", last_coin_a, k + 7);
    check("a_total_rejects", rej_seen_a, 3);
    check("a_queue_drained", exp_q_a.size(), 0);
    check("a_final_pending", int'(pending_a), 0);

    // Overflow on b: 8 insertions every 4 cycles, drain every 10; the 8th hits a full FIFO.
    prev_coin_b = -1;
    k = cyc + 1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i < 7) exp_q_b.push_back((i % 2 == 0) ? 2'd1 : 2'd2);
          ins_b((i % 2) == 0);
        end
      end
      begin
        at_edge(k + 22);
        check("b_full_set", int'(full_b), 1);
        check("b_pending_4", int'(pending_b), 4);
        at_edge(k + 23);
        check("b_full_after_pop", int'(full_b), 0);
        check("b_pending_3", int'(pending_b), 3);
        at_edge(k + 30);
        check("b_overflow_reject", int'(reject_b), 1);
        check("b_pending_held", int'(pending_b), 4);
      end
    join
    @(negedge clk);
    negs(60);
    check("b_overflow_rejects", rej_seen_b, 1);
    check("b_overflow_reject_time", last_rej_b, k + 30);
    check("b_queue_drained", exp_q_b.size(), 0);
    check("b_drained_pending", int'(pending_b), 0);

    // Reset while the second of three queued coins is in EMIT.
    prev_coin_b = -1;
    k = cyc + 1;
    exp_q_b.push_back(2'd1);
    exp_q_b.push_back(2'd2);
    exp_q_b.push_back(2'd1);
    ins_b(1'b1);
    ins_b(1'b0);
    ins_b(1'b1);
    at_edge(k + 13);
    check("b_pre_reset_pending", int'(pending_b), 1);
    check("b_pre_reset_state", int'(fsm_state_b), 1);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("b_reset_coin", int'(coin_b), 0);
    check("b_reset_pending", int'(pending_b), 0);
    check("b_reset_full", int'(full_b), 0);
    check("b_reset_state", int'(fsm_state_b), 0);
    exp_q_b.delete();
    negs(3);
    rst_b = 1'b1;
    negs(40);
    check("b_post_reset_pending", int'(pending_b), 0);
    check("b_total_rejects", rej_seen_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
